// File: rtl/hexuart_tx.sv
// hexuart_tx: buffered hex-word printer over an 8N1 UART TX line.
// Define HEXTX_PREFIX_EN to precede every word with "0x".
module hexuart_tx #(
    parameter int DIGIT      = 8,
    parameter int WCNT       = 868,
    parameter int DEPTH_LOG  = 3,
    parameter int LINE_WORDS = 4
) (
    input  logic               CLK,
    input  logic               RST_X,
    input  logic [DIGIT*4-1:0] DATA,
    input  logic               WE,
    output logic               READY,
    output logic               IDLE,
    output logic               TXD
);

    localparam int DW    = DIGIT * 4;
    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam int CNTW  = DEPTH_LOG + 1;
    localparam int CW    = (WCNT > 1) ? $clog2(WCNT) : 1;

    localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(DEPTH);
    localparam logic [CW-1:0]   BIT_LAST = CW'(WCNT - 1);
    localparam logic [7:0]      DIG8     = 8'(DIGIT);
    localparam logic [15:0]     LW16     = 16'(LINE_WORDS);

`ifdef HEXTX_PREFIX_EN
    localparam logic [7:0] PFX = 8'd2;
`else
    localparam logic [7:0] PFX = 8'd0;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;

    logic [DW-1:0]        r_mem [DEPTH];
    logic [DEPTH_LOG-1:0] r_wptr;
    logic [DEPTH_LOG-1:0] r_rptr;
    logic [CNTW-1:0]      r_count;
    logic                 r_ready;

    logic [1:0]           r_state;
    logic [DW-1:0]        r_shift;
    logic                 r_crlf;
    logic [15:0]          r_line_cnt;
    logic [7:0]           r_char_idx;
    logic [7:0]           r_tx_byte;
    logic [3:0]           r_bit_idx;
    logic [CW-1:0]        r_bit_cnt;
    logic                 r_txd;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_bit_end;
    logic                 w_end_word;
    logic [CNTW-1:0]      w_count_next;
    logic [7:0]           w_off;
    logic [7:0]           w_nchars;
    logic [3:0]           w_nib;
    logic [7:0]           w_char;
    logic [15:0]          w_line_next;

    assign w_push      = WE && r_ready;
    assign w_bit_end   = (r_bit_cnt == BIT_LAST);
    assign w_nchars    = PFX + DIG8 + 8'd1 + {7'd0, r_crlf};
    assign w_end_word  = (r_state == S_SEND) && w_bit_end &&
                         (r_bit_idx == 4'd9) && (r_char_idx == w_nchars);
    assign w_pop       = (r_count != '0) && ((r_state == S_IDLE) || w_end_word);
    assign w_line_next = r_line_cnt + 16'd1;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CNTW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CNTW'(1);
        end
    end

    // Character list of the latched word: [prefix] digits terminator [LF].
    // Offsetting by PFX makes prefix indices wrap above the digit range.
    always_comb begin
        w_off  = r_char_idx - PFX;
        w_nib  = r_shift[DW-1 -: 4];
        w_char = 8'h20;
        if (w_off < DIG8) begin
            w_char = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib}) : (8'h57 + {4'h0, w_nib});
        end else if (w_off == DIG8) begin
            w_char = r_crlf ? 8'h0D : 8'h20;
        end else if (w_off == DIG8 + 8'd1) begin
            w_char = 8'h0A;
        end else begin
            w_char = r_char_idx[0] ? 8'h78 : 8'h30;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ready    <= 1'b1;
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_crlf     <= 1'b0;
            r_line_cnt <= '0;
            r_char_idx <= '0;
            r_tx_byte  <= '0;
            r_bit_idx  <= '0;
            r_bit_cnt  <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_count <= w_count_next;
            r_ready <= (w_count_next != DEPTH_C);
            if (w_push) begin
                r_wptr <= r_wptr + DEPTH_LOG'(1);
            end

            case (r_state)
                S_LOAD: begin
                    r_state   <= S_SEND;
                    r_tx_byte <= w_char;
                    r_txd     <= 1'b0;
                    r_bit_cnt <= '0;
                    r_bit_idx <= '0;
                end
                S_SEND: begin
                    if (!w_bit_end) begin
                        r_bit_cnt <= r_bit_cnt + CW'(1);
                    end else begin
                        r_bit_cnt <= '0;
                        if (r_bit_idx == 4'd9) begin
                            if (r_char_idx == w_nchars) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_tx_byte <= w_char;
                                r_txd     <= 1'b0;
                                r_bit_idx <= '0;
                            end
                        end else if (r_bit_idx == 4'd8) begin
                            // Advance to the next character during the stop bit
                            r_txd      <= 1'b1;
                            r_bit_idx  <= 4'd9;
                            r_char_idx <= r_char_idx + 8'd1;
                            if (w_off < DIG8) begin
                                r_shift <= r_shift << 4;
                            end
                        end else begin
                            r_txd     <= r_tx_byte[0];
                            r_tx_byte <= {1'b0, r_tx_byte[7:1]};
                            r_bit_idx <= r_bit_idx + 4'd1;
                        end
                    end
                end
                default: begin
                end
            endcase

            if (w_pop) begin
                r_state    <= S_LOAD;
                r_rptr     <= r_rptr + DEPTH_LOG'(1);
                r_shift    <= r_mem[r_rptr];
                r_char_idx <= '0;
                if (LINE_WORDS == 0) begin
                    r_crlf <= 1'b0;
                end else if (w_line_next == LW16) begin
                    r_crlf     <= 1'b1;
                    r_line_cnt <= '0;
                end else begin
                    r_crlf     <= 1'b0;
                    r_line_cnt <= w_line_next;
                end
            end
        end
    end

    assign READY = r_ready;
    assign IDLE  = (r_state == S_IDLE) && (r_count == '0);
    assign TXD   = r_txd;

endmodule

// File: doc/hexuart_tx.md
Name: hexuart_tx

Overview:
- Buffered serial hex printer for board-level debug output over the UART TX pin.
- Accepts DIGIT-nibble words into an internal FIFO. Emits each word as lowercase ASCII hex, MSB nibble first, 8N1 framing.
- Each word is followed by a space, or by CR LF when a line fills.
- Successor to the single-word LCD/serial hex controller: adds queuing, a line-break mode, a parametrised bit period and an optional "0x" prefix.

Parameters:
- DIGIT, 8, hex digits per word; DATA width is DIGIT*4.
- WCNT, 868, clocks per serial bit (must be ≥ 2).
- DEPTH_LOG, 3, log2 of FIFO depth (depth = 2**DEPTH_LOG words).
- LINE_WORDS, 4, words per line before CR LF; 0 = never break (space after every word).

Ports:
- CLK  in  1  clock
- RST_X  in  1  synchronous active-low reset
- DATA  in  DIGIT*4  word to print
- WE  in  1  write strobe; accepted only when READY=1
- READY  out  1  FIFO not full (registered)
- IDLE  out  1  FIFO empty and no character in flight
- TXD  out  1  serial output, idle high

Behaviour:
- Reset: one clock, synchronous, active-low; RST_X=0 sampled at a CLK edge → next edge TXD=1, READY=1, IDLE=1; FIFO flushed; line counter=0; bit counter=0.
- Reset mid-character: aborts the character immediately; TXD returns high with no partial stop bit.
- Write: WE=1 and READY=1 at an edge → DATA pushed.
  - WE=1 with READY=0 is dropped with no state change, even if a pop occurs that cycle.
  - READY deasserts on the edge where the count reaches depth.
- Pop/format: when the serialiser is idle and the FIFO is non-empty, the head word is popped and latched on one edge. A character sequence is built from it:
  - DIGIT hex characters: nibble 0–9 → 0x30+n; 10–15 → 0x61+(n-10).
  - Then one terminator.
- Terminator:
  - LINE_WORDS=0: always 0x20.
  - Otherwise the line counter increments per word. When it reaches LINE_WORDS, emit 0x0D then 0x0A and clear the counter; else emit 0x20.
- Frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held exactly WCNT clocks, so a character takes 10*WCNT clocks. Characters are back-to-back with no idle gap.
- Latency: WE into an empty idle block at edge N → FIFO write at N, pop at N+1, TXD=0 (start bit) from edge N+2.
- Next word: after the final stop bit of a word completes, the next word is popped on the same edge if the FIFO is non-empty. Its start bit follows 1 clock later.
- Word length: every word uses the same character count; no leading-zero suppression.
- States: IDLE → LOAD (pop, build char list) → SEND (shift frame, bit counter, char index) → LOAD when FIFO non-empty, else IDLE.
- IDLE output: 1 only in state IDLE with the FIFO empty.
- Simultaneous push and pop: with the FIFO full, a pop frees a slot; READY rises on the following edge.

Optional Feature:
- Macro HEXTX_PREFIX_EN.
  - Defined: each word is preceded by "0x" (0x30, 0x78), giving DIGIT+3 or DIGIT+4 characters per word.
  - Undefined: no prefix.
- The line-break rules are unchanged either way.

Test Plan:
- DIGIT=8, WCNT=4, LINE_WORDS=0: write 0x12ABCDEF once → TXD carries 31 32 61 62 63 64 65 66 20. First start bit at write+2. IDLE returns 1 exactly 360 clocks after the first start bit.
- LINE_WORDS=2: write 0x00000000 then 0xFFFFFFFF back-to-back → "00000000 ffffffff\r\n"; second word starts with no gap after the first space.
- DEPTH_LOG=2: write 6 words on consecutive cycles while the first is transmitting → 5 accepted (1 popped plus 4 queued). The 6th is dropped while READY=0, and only 5 words appear on TXD.
- Reset asserted mid-way through the data bits of the 3rd character → next edge TXD=1, READY=1, IDLE=1. A subsequent write of 0x00000001 prints "00000001 " from a zero line count.
- Bit timing, WCNT=5: measure each TXD level run. Start bit = 5 clocks; 0x31 ('1') data run lengths match 5-clock multiples; stop bit = 5 clocks.
- With HEXTX_PREFIX_EN defined: write 0x0000BEEF → "0x0000beef ".
